// File: rtl/masked_serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial two-share masked adder.
package masked_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two Boolean shares of one bit: value = sh0 ^ sh1.
    typedef struct packed {
        logic sh0;
        logic sh1;
    } share_t;

    localparam int RND_PER_BIT = 2;

endpackage

// File: rtl/masked_serial_adder_ctrl_if.sv
// Operand, randomness and result handshake bundle of the masked serial adder.
interface masked_serial_adder_ctrl_if
    import masked_arith_pkg::*;
#(
    parameter int W = 8
);
    logic                   start;
    logic [W-1:0]           a0;
    logic [W-1:0]           a1;
    logic [W-1:0]           b0;
    logic [W-1:0]           b1;
    logic                   cin0;
    logic                   cin1;
    logic [RND_PER_BIT-1:0] rnd;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic                   busy;
    logic [W-1:0]           s0;
    logic [W-1:0]           s1;
    logic                   cout0;
    logic                   cout1;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  start, a0, a1, b0, b1, cin0, cin1, rnd, rnd_valid, out_ready,
        output rnd_ready, busy, s0, s1, cout0, cout1, out_valid
    );

    modport master (
        output start, a0, a1, b0, b1, cin0, cin1, rnd, rnd_valid, out_ready,
        input  rnd_ready, busy, s0, s1, cout0, cout1, out_valid
    );
endinterface

// File: rtl/masked_serial_adder_ctrl_fa_stage.sv
// Combinational first-order masked full adder built from two masked half-adder cells.
module masked_ha
    import masked_arith_pkg::*;
(
    input  share_t x,
    input  share_t y,
    input  logic   r,
    output share_t h,
    output share_t p
);
    assign h.sh0 = x.sh0 ^ y.sh0;
    assign h.sh1 = x.sh1 ^ y.sh1;
    // Cross-share products are only ever combined together with the fresh bit r.
    assign p.sh0 = (x.sh0 & y.sh0) ^ (x.sh0 & y.sh1) ^ r;
    assign p.sh1 = (x.sh1 & y.sh1) ^ (x.sh1 & y.sh0) ^ r;
endmodule

module masked_fa_stage
    import masked_arith_pkg::*;
(
    input  share_t                 a,
    input  share_t                 b,
    input  share_t                 c,
    input  logic [RND_PER_BIT-1:0] rnd,
    output share_t                 sum,
    output share_t                 carry
);
    share_t h;
    share_t p;
    share_t q;

    masked_ha u_ha_ab (
        .x (a),
        .y (b),
        .r (rnd[0]),
        .h (h),
        .p (p)
    );

    masked_ha u_ha_hc (
        .x (h),
        .y (c),
        .r (rnd[1]),
        .h (sum),
        .p (q)
    );

    assign carry.sh0 = p.sh0 ^ q.sh0;
    assign carry.sh1 = p.sh1 ^ q.sh1;
endmodule

// File: rtl/masked_serial_adder_ctrl.sv
// Bit-serial masked adder controller: one operand bit per accepted random word,
// carry shares registered between bits, result held until the consumer accepts it.
module masked_serial_adder_ctrl
    import masked_arith_pkg::*;
#(
    parameter int W = 8
) (
    input logic                        clk,
    input logic                        rst,
    masked_serial_adder_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a0_sh;
    logic [W-1:0]     a1_sh;
    logic [W-1:0]     b0_sh;
    logic [W-1:0]     b1_sh;
    logic [W-1:0]     s0_q;
    logic [W-1:0]     s1_q;
    share_t           c_q;
    logic             cout0_q;
    logic             cout1_q;
    logic             rnd_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    share_t a_bit;
    share_t b_bit;
    share_t sum_bit;
    share_t carry_bit;
    logic   step;

    // Operands shift right so the bit under processing is always at position 0.
    assign a_bit = '{sh0: a0_sh[0], sh1: a1_sh[0]};
    assign b_bit = '{sh0: b0_sh[0], sh1: b1_sh[0]};
    assign step  = rnd_ready_q & bus.rnd_valid;

    masked_fa_stage u_fa (
        .a     (a_bit),
        .b     (b_bit),
        .c     (c_q),
        .rnd   (bus.rnd),
        .sum   (sum_bit),
        .carry (carry_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a0_sh       <= '0;
            a1_sh       <= '0;
            b0_sh       <= '0;
            b1_sh       <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            c_q         <= '0;
            cout0_q     <= 1'b0;
            cout1_q     <= 1'b0;
            rnd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a0_sh       <= bus.a0;
                        a1_sh       <= bus.a1;
                        b0_sh       <= bus.b0;
                        b1_sh       <= bus.b1;
                        c_q         <= '{sh0: bus.cin0, sh1: bus.cin1};
                        idx         <= '0;
                        rnd_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (step) begin
                        a0_sh <= a0_sh >> 1;
                        a1_sh <= a1_sh >> 1;
                        b0_sh <= b0_sh >> 1;
                        b1_sh <= b1_sh >> 1;
                        s0_q  <= {sum_bit.sh0, s0_q[W-1:1]};
                        s1_q  <= {sum_bit.sh1, s1_q[W-1:1]};
                        c_q   <= carry_bit;
                        if (idx == LAST_IDX) begin
                            rnd_ready_q <= 1'b0;
                            state       <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the final carry shares with out_valid.
                    if (!out_valid_q) begin
                        cout0_q     <= c_q.sh0;
                        cout1_q     <= c_q.sh1;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        idx         <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rnd_ready = rnd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s0        = s0_q;
    assign bus.s1        = s1_q;
    assign bus.cout0     = cout0_q;
    assign bus.cout1     = cout1_q;
endmodule

// File: tb/tb_masked_serial_adder_ctrl.sv
// Scoreboard bench for the masked serial adder: unmasked results, latency, stalls,
// back-pressure, reset abort and randomness dependence.
module tb_masked_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   rnd_used;
    logic [8:0] exp_q[$];

    masked_serial_adder_ctrl_if #(.W(8)) bus ();

    masked_serial_adder_ctrl #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fresh random word offered every cycle.
    initial begin
        bus.rnd = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            bus.rnd = 2'($urandom_range(0, 3));
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.rnd_valid && bus.rnd_ready) rnd_used <= rnd_used + 1;
    end

    task automatic do_op(input logic [7:0] xa0, input logic [7:0] xa1,
                         input logic [7:0] xb0, input logic [7:0] xb1,
                         input logic xc0, input logic xc1,
                         input int st_at, input int st_len, output int lat);
        logic [7:0] ua;
        logic [7:0] ub;
        logic [8:0] e;
        ua = xa0 ^ xa1;
        ub = xb0 ^ xb1;
        e  = {1'b0, ua} + {1'b0, ub} + {8'd0, xc0 ^ xc1};
        exp_q.push_back(e);
        bus.a0 = xa0; bus.a1 = xa1; bus.b0 = xb0; bus.b1 = xb1;
        bus.cin0 = xc0; bus.cin1 = xc1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.rnd_valid = !(lat >= st_at && lat < st_at + st_len);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.rnd_valid = 1'b1;
        if (!bus.out_valid) begin
            total++; bad++;
            $display("FAIL op_timeout out_valid got=%b want=1 after %0d cycles", bus.out_valid, lat);
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy, bus.rnd_ready, bus.out_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {bus.busy, bus.rnd_ready, bus.out_valid});
        end
        total++;
        if ({bus.s0, bus.s1, bus.cout0, bus.cout1} !== 18'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {bus.s0, bus.s1, bus.cout0, bus.cout1});
        end
    endtask

    task automatic test_basic();
        int lat;
        int used0;
        logic [8:0] e;
        used0 = rnd_used;
        do_op(8'h3C, 8'h66, 8'h81, 8'h42, 1'b0, 1'b0, 100, 0, lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++;
        if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
            bad++; $display("FAIL basic_result got=%h want=%h", {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
        end
        total++;
        if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== 9'h11D) begin
            bad++; $display("FAIL basic_value got=%h want=11d", {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1});
        end
        total++;
        if (rnd_used - used0 !== 8) begin bad++; $display("FAIL basic_rnd_count got=%0d want=8", rnd_used - used0); end
        total++;
        if ({bus.busy, bus.rnd_ready} !== 2'b10) begin
            bad++; $display("FAIL done_flags got=%b want=10", {bus.busy, bus.rnd_ready});
        end
        accept();
        total++;
        if ({bus.busy, bus.out_valid} !== 2'b00) begin
            bad++; $display("FAIL accept_flags got=%b want=00", {bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_stall();
        int lat;
        int used0;
        logic [8:0] e;
        used0 = rnd_used;
        do_op(8'h3C, 8'h66, 8'h81, 8'h42, 1'b0, 1'b0, 3, 3, lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 12) begin bad++; $display("FAIL stall_latency got=%0d want=12", lat); end
        total++;
        if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
            bad++; $display("FAIL stall_result got=%h want=%h", {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
        end
        total++;
        if (rnd_used - used0 !== 8) begin bad++; $display("FAIL stall_rnd_count got=%0d want=8", rnd_used - used0); end
        accept();
    endtask

    task automatic test_carry_wrap();
        int lat;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] e;
        ra = 8'($urandom);
        rb = 8'($urandom);
        do_op(ra, ra ^ 8'hFF, rb, rb, 1'b1, 1'b0, 100, 0, lat);
        e = exp_q.pop_front();
        total++;
        if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e || e !== 9'h100) begin
            bad++; $display("FAIL carry_wrap got=%h want=100", {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1});
        end
        accept();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [8:0] e;
        logic [17:0] held;
        do_op(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b1, 100, 0, lat);
        e = exp_q.pop_front();
        held = {bus.s0, bus.s1, bus.cout0, bus.cout1};
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 2);
            bus.a0 = 8'hFF; bus.b0 = 8'hFF;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            total++;
            if (bus.out_valid !== 1'b1 || {bus.s0, bus.s1, bus.cout0, bus.cout1} !== held) begin
                bad++; $display("FAIL backpressure_hold cyc=%0d got=%b/%h want=1/%h", k, bus.out_valid,
                                {bus.s0, bus.s1, bus.cout0, bus.cout1}, held);
            end
        end
        total++;
        if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
            bad++; $display("FAIL backpressure_result got=%h want=%h", {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
        end
        accept();
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || {bus.s0, bus.s1, bus.cout0, bus.cout1} !== held) begin
            bad++; $display("FAIL after_accept got=%b/%h want=0/%h", bus.busy, {bus.s0, bus.s1, bus.cout0, bus.cout1}, held);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [8:0] e;
        bus.a0 = 8'hA5; bus.a1 = 8'h0F; bus.b0 = 8'h3C; bus.b1 = 8'hC3;
        bus.cin0 = 1'b1; bus.cin1 = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b want=1", bus.busy); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.rnd_ready, bus.out_valid} !== 3'b000) begin
            bad++; $display("FAIL midreset_ctrl got=%b want=000", {bus.busy, bus.rnd_ready, bus.out_valid});
        end
        total++;
        if ({bus.s0, bus.s1, bus.cout0, bus.cout1} !== 18'd0) begin
            bad++; $display("FAIL midreset_data got=%h want=0", {bus.s0, bus.s1, bus.cout0, bus.cout1});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(8'h9E, 8'h21, 8'h70, 8'h0D, 1'b0, 1'b1, 100, 0, lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 9 || {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
            bad++; $display("FAIL post_reset_op got=%0d/%h want=9/%h", lat, {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
        end
        accept();
    endtask

    task automatic test_random();
        int lat;
        int st_at;
        int st_len;
        int used0;
        logic [8:0] e;
        used0 = rnd_used;
        for (int n = 0; n < 1000; n++) begin
            st_at  = $urandom_range(0, 10);
            st_len = $urandom_range(0, 3);
            do_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), st_at, st_len, lat);
            e = exp_q.pop_front();
            total++;
            if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
                bad++; $display("FAIL random_result op=%0d got=%h want=%h", n, {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
            end
            total++;
            if (lat !== 9 + ((st_at <= 7) ? st_len : 0)) begin
                bad++; $display("FAIL random_latency op=%0d got=%0d want=%0d", n, lat, 9 + ((st_at <= 7) ? st_len : 0));
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            accept();
        end
        total++;
        if (rnd_used - used0 !== 8000) begin bad++; $display("FAIL random_rnd_count got=%0d want=8000", rnd_used - used0); end
    endtask

    task automatic test_mask_variation();
        int lat;
        int differ;
        logic [8:0] e;
        logic [7:0] first_s0;
        differ = 0;
        for (int n = 0; n < 20; n++) begin
            do_op(8'h5A, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0, 100, 0, lat);
            e = exp_q.pop_front();
            total++;
            if ({bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1} !== e) begin
                bad++; $display("FAIL fixed_result run=%0d got=%h want=%h", n, {bus.cout0 ^ bus.cout1, bus.s0 ^ bus.s1}, e);
            end
            if (n == 0) first_s0 = bus.s0;
            else if (bus.s0 !== first_s0) differ++;
            accept();
        end
        total++;
        if (differ == 0) begin bad++; $display("FAIL s0_distribution got=constant %h want=varying", first_s0); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rnd_used = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        bus.cin0 = 1'b0; bus.cin1 = 1'b0;
        bus.rnd_valid = 1'b1;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_basic();
        test_stall();
        test_carry_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_mask_variation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
